des_sbox_serial: RTL

- Downstream neighbour of the E expansion stage in the DES round datapath.
- Takes the 48-bit expanded right half and the 48-bit round subkey, XORs them, and applies S-boxes S1..S8.
- S-boxes are applied in a time-multiplexed way, SBOX_PER_CYCLE groups per cycle, to save area.
- Delivers the 32-bit substitution result (the P-permutation input) over a valid/ready handshake.

---
 rtl/des_pkg.sv | 31 +++
 rtl/des_sbox_serial_if.sv | 20 ++
 rtl/des_sbox_unit.sv | 10 +
 rtl/des_sbox_serial.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES S-box tables, lookup helper and control state encoding.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Row index = {group-1, row}; each row holds columns 0..15, column 0 in the top nibble.
    localparam logic [63:0] SBOX_ROWS [0:31] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // g is the zero-based group; six = {b1,b2,b3,b4,b5,b6}.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] g, input logic [5:0] six);
        logic [63:0] row;
        logic [5:0]  lsb;
        row = SBOX_ROWS[{g, six[5], six[0]}];
        lsb = {~six[4:1], 2'b00};
        return row[lsb +: 4];
    endfunction

endpackage

// File: rtl/des_sbox_serial_if.sv
// rtl/des_sbox_serial_if.sv - Input and output handshakes of the serial S-box stage.
interface des_sbox_serial_if;
    logic        in_valid;
    logic        in_ready;
    logic [48:0] data_in;
    logic [48:0] subkey;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] data_out;

    modport master (
        output in_valid, data_in, subkey, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, subkey, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/des_sbox_unit.sv
// rtl/des_sbox_unit.sv - Combinational lookup of one S-box group selected by index.
module des_sbox_unit
    import des_pkg::*;
(
    input  logic [2:0] grp,
    input  logic [5:0] six,
    output logic [3:0] nib
);
    assign nib = sbox_lookup(grp, six);
endmodule

// File: rtl/des_sbox_serial.sv
// rtl/des_sbox_serial.sv - Key mix plus time-multiplexed S1..S8 substitution, handshaked in and out.
module des_sbox_serial
    import des_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 1
) (
    input  logic clk,
    input  logic rst,
    des_sbox_serial_if.slave bus
);
    localparam int NSTEP = 8 / SBOX_PER_CYCLE;

    generate
        if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
              SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_param
            $error("des_sbox_serial: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [7:0][5:0] x_q, x_d;
    logic [7:0][3:0] res_q, res_d;
    logic [7:0][3:0] dout_q, dout_d;
    logic            out_valid_q, out_valid_d;

    logic            in_ready_w;
    logic            accept;
    logic            last_step;
    logic [7:0][5:0] x_in;
    logic [2:0]      grp [SBOX_PER_CYCLE];
    logic [3:0]      nib [SBOX_PER_CYCLE];
    logic            unused_bits;

    assign unused_bits = bus.data_in[0] ^ bus.subkey[0];

    assign in_ready_w = !rst && ((state_q == IDLE) || (state_q == DONE && bus.out_ready));
    assign accept     = bus.in_valid && in_ready_w;
    assign last_step  = (step_q == 3'(NSTEP - 1));

    genvar j;
    generate
        for (j = 0; j < SBOX_PER_CYCLE; j++) begin : g_unit
            assign grp[j] = 3'(int'(step_q) * SBOX_PER_CYCLE + j);
            des_sbox_unit u_unit (
                .grp (grp[j]),
                .six (x_q[grp[j]]),
                .nib (nib[j])
            );
        end
    endgenerate

    // Regroup the mixed bits so x_in[g] = {b1..b6} of group g+1.
    always_comb begin
        x_in = '0;
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 6; k++) begin
                x_in[g][5-k] = bus.data_in[6*g+1+k] ^ bus.subkey[6*g+1+k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        x_d         = x_q;
        res_d       = res_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    x_d     = x_in;
                    res_d   = '0;
                    step_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < SBOX_PER_CYCLE; i++) begin
                    res_d[grp[i]] = nib[i];
                end
                step_d = step_q + 3'd1;
                if (last_step) begin
                    step_d      = '0;
                    dout_d      = res_d;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (accept) begin
                        x_d     = x_in;
                        res_d   = '0;
                        step_d  = '0;
                        state_d = BUSY;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            x_q         <= '0;
            res_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            x_q         <= x_d;
            res_q       <= res_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // S-box nibble MSB lands on the lowest DES bit number of its 4-bit field.
    always_comb begin
        bus.data_out = '0;
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 4; k++) begin
                bus.data_out[4*g+1+k] = dout_q[g][3-k];
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;

endmodule
